// File: rtl/apb_fsm_controller.sv
// APB transfer sequencer for the AHB-to-APB bridge.
// Turns each accepted AHB address phase into a two-phase APB access (SETUP, ENABLE) and
// stretches the AHB data phase through Hreadyout. Every output comes straight from a flop;
// the next value of each output is computed from the next state.
module apb_fsm_controller #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEL_WIDTH  = 3
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic                  valid,
  input  logic [ADDR_WIDTH-1:0] Haddr,
  input  logic                  Hwrite,
  input  logic [DATA_WIDTH-1:0] Hwdata,
  input  logic [SEL_WIDTH-1:0]  tempselx,
  output logic [SEL_WIDTH-1:0]  Pselx,
  output logic                  Penable,
  output logic                  Pwrite,
  output logic [ADDR_WIDTH-1:0] Paddr,
  output logic [DATA_WIDTH-1:0] Pwdata,
  output logic                  Hreadyout
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WWAIT  = 2'd1;
  localparam logic [1:0] SETUP  = 2'd2;
  localparam logic [1:0] ENABLE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  accept;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic                  write_q;

  logic [SEL_WIDTH-1:0]  pselx_d;
  logic                  penable_d;
  logic                  pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_d;
  logic                  hreadyout_d;

  // Next state; an address phase is only accepted where Hreadyout is high (IDLE, ENABLE).
  always_comb begin
    accept  = valid && ((state_q == IDLE) || (state_q == ENABLE));
    state_d = state_q;
    case (state_q)
      IDLE, ENABLE: begin
        if (valid) begin
          state_d = Hwrite ? WWAIT : SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      WWAIT:   state_d = SETUP;
      SETUP:   state_d = ENABLE;
      default: state_d = IDLE;
    endcase
  end

  // Next output values, decoded from the state being entered.
  always_comb begin
    pselx_d     = '0;
    penable_d   = (state_d == ENABLE);
    hreadyout_d = (state_d == IDLE) || (state_d == ENABLE);
    pwrite_d    = Pwrite;
    paddr_d     = Paddr;
    pwdata_d    = Pwdata;
    case (state_d)
      SETUP: begin
        // A read enters SETUP on the accepting edge itself, so take the live AHB values;
        // a write comes from WWAIT and uses what was captured one cycle earlier.
        pselx_d  = accept ? tempselx : sel_q;
        paddr_d  = accept ? Haddr    : addr_q;
        pwrite_d = accept ? Hwrite   : write_q;
      end
      ENABLE:  pselx_d = Pselx;
      default: pselx_d = '0;
    endcase
    // Write data is valid during the WWAIT cycle, which is always followed by SETUP.
    if (state_q == WWAIT) begin
      pwdata_d = Hwdata;
    end
  end

  // Capture the address-phase attributes of every accepted transfer.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      addr_q  <= '0;
      sel_q   <= '0;
      write_q <= 1'b0;
    end else if (accept) begin
      addr_q  <= Haddr;
      sel_q   <= tempselx;
      write_q <= Hwrite;
    end
  end

  // State and registered outputs.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q   <= IDLE;
      Pselx     <= '0;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
      Paddr     <= '0;
      Pwdata    <= '0;
      Hreadyout <= 1'b1;
    end else begin
      state_q   <= state_d;
      Pselx     <= pselx_d;
      Penable   <= penable_d;
      Pwrite    <= pwrite_d;
      Paddr     <= paddr_d;
      Pwdata    <= pwdata_d;
      Hreadyout <= hreadyout_d;
    end
  end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Scoreboard bench for apb_fsm_controller: the driver pushes the expected output set for
// each clock edge it issues; a separate monitor pops and compares on the falling edge.
module tb_apb_fsm_controller;

  logic        Hclk = 1'b0;
  logic        Hresetn = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] Haddr = '0;
  logic        Hwrite = 1'b0;
  logic [31:0] Hwdata = '0;
  logic [2:0]  tempselx = '0;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic        Hreadyout;

  typedef struct packed {
    logic [2:0]  sel;
    logic        en;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  apb_fsm_controller #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .SEL_WIDTH (3)
  ) dut (
    .Hclk     (Hclk),
    .Hresetn  (Hresetn),
    .valid    (valid),
    .Haddr    (Haddr),
    .Hwrite   (Hwrite),
    .Hwdata   (Hwdata),
    .tempselx (tempselx),
    .Pselx    (Pselx),
    .Penable  (Penable),
    .Pwrite   (Pwrite),
    .Paddr    (Paddr),
    .Pwdata   (Pwdata),
    .Hreadyout(Hreadyout)
  );

  always #5 Hclk = ~Hclk;

  function automatic exp_t mk(input logic [2:0] sel, input logic en, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic rdy);
    exp_t e;
    e.sel = sel; e.en = en; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdy = rdy;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic chk_all(input string nm, input exp_t e);
    chk({nm, ".Pselx"},     {29'd0, Pselx},     {29'd0, e.sel});
    chk({nm, ".Penable"},   {31'd0, Penable},   {31'd0, e.en});
    chk({nm, ".Pwrite"},    {31'd0, Pwrite},    {31'd0, e.wr});
    chk({nm, ".Paddr"},     Paddr,              e.addr);
    chk({nm, ".Pwdata"},    Pwdata,             e.wdata);
    chk({nm, ".Hreadyout"}, {31'd0, Hreadyout}, {31'd0, e.rdy});
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the coming edge.
  task automatic cyc(input string nm, input logic v, input logic w, input logic [31:0] a,
                     input logic [2:0] s, input logic [31:0] wd, input exp_t e);
    valid = v; Hwrite = w; Haddr = a; tempselx = s; Hwdata = wd;
    @(posedge Hclk);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge Hclk);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge Hclk);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk_all(nm, e);
      end
    end
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset, released between edges.
    #1 Hresetn = 1'b0;
    repeat (3) @(posedge Hclk);
    @(negedge Hclk);
    Hresetn = 1'b1;
    #1 chk_all("reset", mk(3'b000, 0, 0, 32'h0, 32'h0, 1));
    @(negedge Hclk);

    // Single read.
    cyc("rd_setup", 1, 0, 32'h8000_0010, 3'b001, 32'h0,
        mk(3'b001, 0, 0, 32'h8000_0010, 32'h0, 0));
    cyc("rd_enable", 0, 0, 32'h0, 3'b000, 32'h0,
        mk(3'b001, 1, 0, 32'h8000_0010, 32'h0, 1));
    cyc("rd_idle", 0, 0, 32'h0, 3'b000, 32'h0,
        mk(3'b000, 0, 0, 32'h8000_0010, 32'h0, 1));

    // Single write; Hwdata valid in the data phase (WWAIT cycle) and held.
    cyc("wr_wwait", 1, 1, 32'h8400_0004, 3'b010, 32'h0,
        mk(3'b000, 0, 0, 32'h8000_0010, 32'h0, 0));
    cyc("wr_setup", 0, 0, 32'h0, 3'b000, 32'hDEAD_BEEF,
        mk(3'b010, 0, 1, 32'h8400_0004, 32'hDEAD_BEEF, 0));
    cyc("wr_enable", 0, 0, 32'h0, 3'b000, 32'hDEAD_BEEF,
        mk(3'b010, 1, 1, 32'h8400_0004, 32'hDEAD_BEEF, 1));
    cyc("wr_idle", 0, 0, 32'h0, 3'b000, 32'h0,
        mk(3'b000, 0, 1, 32'h8400_0004, 32'hDEAD_BEEF, 1));

    // Read, then write presented in its ENABLE, then read presented in the write's ENABLE.
    cyc("b2b_rd_setup", 1, 0, 32'h8800_0000, 3'b100, 32'h5555_5555,
        mk(3'b100, 0, 0, 32'h8800_0000, 32'hDEAD_BEEF, 0));
    cyc("b2b_rd_enable", 0, 0, 32'h0, 3'b000, 32'h0,
        mk(3'b100, 1, 0, 32'h8800_0000, 32'hDEAD_BEEF, 1));
    cyc("b2b_wr_wwait", 1, 1, 32'h8000_0020, 3'b001, 32'h0,
        mk(3'b000, 0, 0, 32'h8800_0000, 32'hDEAD_BEEF, 0));
    cyc("b2b_wr_setup", 0, 0, 32'h0, 3'b000, 32'h1234_5678,
        mk(3'b001, 0, 1, 32'h8000_0020, 32'h1234_5678, 0));
    cyc("b2b_wr_enable", 0, 0, 32'h0, 3'b000, 32'h1234_5678,
        mk(3'b001, 1, 1, 32'h8000_0020, 32'h1234_5678, 1));
    // Read data on Hwdata must not reach Pwdata.
    cyc("b2b_rd2_setup", 1, 0, 32'h8400_0008, 3'b010, 32'hFFFF_0000,
        mk(3'b010, 0, 0, 32'h8400_0008, 32'h1234_5678, 0));
    cyc("b2b_rd2_enable", 0, 0, 32'h0, 3'b000, 32'hFFFF_0000,
        mk(3'b010, 1, 0, 32'h8400_0008, 32'h1234_5678, 1));
    cyc("b2b_idle", 0, 0, 32'h0, 3'b000, 32'h0,
        mk(3'b000, 0, 0, 32'h8400_0008, 32'h1234_5678, 1));

    // valid low with noise on the other inputs: stays idle, held values unchanged.
    for (int i = 0; i < 10; i++) begin
      cyc("idle_noise", 0, 1'($urandom_range(1, 0)), $urandom, 3'($urandom_range(7, 0)),
          $urandom, mk(3'b000, 0, 0, 32'h8400_0008, 32'h1234_5678, 1));
    end

    // Asynchronous reset during WWAIT of a write.
    cyc("rst_wwait", 1, 1, 32'h8C00_0000, 3'b100, 32'h0,
        mk(3'b000, 0, 0, 32'h8400_0008, 32'h1234_5678, 0));
    valid = 1'b0; Hwdata = 32'hCAFE_F00D;
    #2 Hresetn = 1'b0;
    #1 chk_all("async_rst", mk(3'b000, 0, 0, 32'h0, 32'h0, 1));
    @(posedge Hclk);
    @(negedge Hclk);
    Hresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc("post_rst", 0, 0, 32'h0, 3'b000, 32'hCAFE_F00D,
          mk(3'b000, 0, 0, 32'h0, 32'h0, 1));
    end

    @(posedge Hclk);
    #1 chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
